// File: rtl/tick_timer_ctrl.sv
// Sequencer for the external 16-bit tick counter: counts completed ticks up to a
// latched limit and pulses timeout, with start/restart, pause/resume and cancel.
`timescale 1ns/1ps
module tick_timer_ctrl #(
    parameter int W_MS = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            iniciar,
    input  logic            pausar,
    input  logic            cancelar,
    input  logic [W_MS-1:0] limite_ms,
    input  logic            cnt_rco,
    output logic            cnt_clr_n,
    output logic            cnt_ld_n,
    output logic            cnt_ent,
    output logic            cnt_enp,
    output logic [3:0]      cnt_d,
    output logic [W_MS-1:0] ms_decorridos,
    output logic            ocupado,
    output logic            timeout,
    output logic [2:0]      db_estado
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } estado_t;

    estado_t         estado;
    estado_t         prox;
    logic [W_MS-1:0] limite_q;
    logic [W_MS-1:0] ms_prox;
    logic            fim_tick;
    logic            atinge;

    assign ms_prox  = ms_decorridos + W_MS'(1);
    assign fim_tick = (estado == RUN) && cnt_rco;
    assign atinge   = (ms_prox == limite_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= IDLE;
        else       estado <= prox;
    end

    // A tick landing on the same edge as pausar is counted before pausing.
    always_comb begin
        prox = estado;
        if (cancelar) begin
            prox = IDLE;
        end else if (iniciar) begin
            prox = (limite_ms == '0) ? DONE : RUN;
        end else begin
            case (estado)
                IDLE:    prox = IDLE;
                RUN: begin
                    if (cnt_rco && atinge) prox = DONE;
                    else if (pausar)       prox = PAUSE;
                end
                PAUSE:   if (!pausar) prox = RUN;
                DONE:    prox = IDLE;
                default: prox = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            limite_q      <= '0;
            ms_decorridos <= '0;
        end else if (!cancelar) begin
            if (iniciar) begin
                limite_q      <= limite_ms;
                ms_decorridos <= '0;
            end else if (fim_tick) begin
                ms_decorridos <= ms_prox;
            end
        end
    end

    // clr_n also drops on a restart so the counter begins the new run from zero.
    always_comb begin
        cnt_clr_n = 1'b0;
        cnt_ent   = 1'b0;
        cnt_enp   = 1'b0;
        ocupado   = 1'b0;
        timeout   = 1'b0;
        case (estado)
            RUN: begin
                cnt_clr_n = ~cnt_rco & ~iniciar;
                cnt_ent   = 1'b1;
                cnt_enp   = 1'b1;
                ocupado   = 1'b1;
            end
            PAUSE: begin
                cnt_clr_n = ~iniciar;
                ocupado   = 1'b1;
            end
            DONE:    timeout = 1'b1;
            default: ;
        endcase
    end

    assign cnt_ld_n  = 1'b1;
    assign cnt_d     = 4'b0000;
    assign db_estado = estado;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Bench for tick_timer_ctrl: drives it with a behavioural 163-style counter and
// compares every cycle against a cycle-count model of the timer.
`timescale 1ns/1ps
module tb_tick_timer_ctrl;

    localparam int W_MS = 16;
    // The controller only sees rco, so the counter uses a short terminal count.
    localparam int TC  = 99;
    localparam int PER = TC + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            iniciar;
    logic            pausar;
    logic            cancelar;
    logic [W_MS-1:0] limite_ms;
    logic            cnt_rco;
    logic            cnt_clr_n;
    logic            cnt_ld_n;
    logic            cnt_ent;
    logic            cnt_enp;
    logic [3:0]      cnt_d;
    logic [W_MS-1:0] ms_decorridos;
    logic            ocupado;
    logic            timeout;
    logic [2:0]      db_estado;
    logic [15:0]     q = 16'd0;

    int n_checks = 0;
    int n_errors = 0;

    int m_busy, m_paused, m_pulse, m_lim, m_ms, m_active;

    tick_timer_ctrl #(.W_MS(W_MS)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
        .cancelar(cancelar), .limite_ms(limite_ms), .cnt_rco(cnt_rco),
        .cnt_clr_n(cnt_clr_n), .cnt_ld_n(cnt_ld_n), .cnt_ent(cnt_ent),
        .cnt_enp(cnt_enp), .cnt_d(cnt_d), .ms_decorridos(ms_decorridos),
        .ocupado(ocupado), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!cnt_clr_n)               q <= 16'd0;
        else if (cnt_ent && cnt_enp)  q <= q + 16'd1;
    end
    assign cnt_rco = (q == 16'(TC)) && cnt_ent;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_paused = 0; m_pulse = 0;
        m_lim = 0; m_ms = 0; m_active = 0;
    endtask

    // Timer seen as "enabled clock edges since start": a tick completes every PER of them.
    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (cancelar) begin
            m_busy = 0; m_paused = 0; m_pulse = 0;
        end else if (iniciar) begin
            m_lim = int'(limite_ms); m_ms = 0; m_active = 0; m_paused = 0;
            m_pulse = (m_lim == 0) ? 1 : 0;
            m_busy  = (m_lim != 0) ? 1 : 0;
        end else if (m_busy != 0) begin
            m_pulse = 0;
            if (m_paused == 0) begin
                m_active++;
                if (m_active % PER == 0) begin
                    m_ms = m_active / PER;
                    if (m_ms == m_lim) begin
                        m_busy = 0; m_paused = 0; m_pulse = 1;
                    end
                end
            end
            if (m_busy != 0) m_paused = pausar ? 1 : 0;
        end else begin
            m_pulse = 0;
        end
    endtask

    task automatic compare_all();
        int exp_state;
        exp_state = (m_pulse != 0) ? 3 : (m_busy != 0) ? ((m_paused != 0) ? 2 : 1) : 0;
        check("estado",  int'(db_estado), exp_state);
        check("ocupado", int'(ocupado), m_busy);
        check("timeout", int'(timeout), m_pulse);
        check("ms",      int'(ms_decorridos), m_ms);
        check("ent",     int'(cnt_ent), (m_busy != 0 && m_paused == 0) ? 1 : 0);
        check("enp",     int'(cnt_enp), (m_busy != 0 && m_paused == 0) ? 1 : 0);
        check("ld_n",    int'(cnt_ld_n), 1);
        check("d",       int'(cnt_d), 0);
        if (m_busy != 0) check("q", int'(q), m_active % PER);
        else             check("clr_n", int'(cnt_clr_n), 0);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
        @(negedge clock);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic start(input int lim);
        limite_ms = W_MS'(lim);
        iniciar   = 1'b1;
        cycle();
        iniciar   = 1'b0;
    endtask

    task automatic wait_timeout(input int bound, output int n);
        n = 0;
        while (!timeout && n < bound) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; iniciar = 1'b0; pausar = 1'b0; cancelar = 1'b0; limite_ms = '0;
        model_reset();
        #2 reset = 1'b1;
        #1;
        check("rst0_estado", int'(db_estado), 0);
        check("rst0_clr_n",  int'(cnt_clr_n), 0);
        @(negedge clock);
        run(2);
        reset = 1'b0;
        run(3);

        // Asynchronous reset in the middle of a run
        start(3);
        run(PER / 2 + 7);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rstm_estado",  int'(db_estado), 0);
        check("rstm_ocupado", int'(ocupado), 0);
        check("rstm_timeout", int'(timeout), 0);
        check("rstm_ent",     int'(cnt_ent), 0);
        check("rstm_clr_n",   int'(cnt_clr_n), 0);
        check("rstm_ms",      int'(ms_decorridos), 0);
        @(negedge clock);
        cycle();
        check("rstm_q", int'(q), 0);
        reset = 1'b0;
        run(2);

        // Limit 2
        start(2);
        wait_timeout(10 * PER, n);
        check("l2_latency", n, 2 * PER);
        cycle();
        check("l2_ms_final", int'(ms_decorridos), 2);

        // Limit 3 with a 1000-cycle pause during tick 2
        start(3);
        run(PER + 30);
        pausar = 1'b1;
        run(1000);
        pausar = 1'b0;
        wait_timeout(10 * PER, n);
        check("pause_latency", PER + 30 + 1000 + n, 3 * PER + 1000);
        run(2);

        // Cancel mid tick 2
        start(5);
        run(PER + PER / 2);
        cancelar = 1'b1;
        cycle();
        cancelar = 1'b0;
        run(6 * PER);
        check("cancel_ms", int'(ms_decorridos), 1);

        // Restart while running
        start(4);
        run(PER + PER / 5);
        start(1);
        wait_timeout(10 * PER, n);
        check("restart_latency", n, PER);
        run(2);

        // Zero limit and simultaneous start/cancel
        start(0);
        check("l0_timeout", int'(timeout), 1);
        cycle();
        limite_ms = W_MS'(2); iniciar = 1'b1; cancelar = 1'b1;
        cycle();
        iniciar = 1'b0; cancelar = 1'b0;
        check("startcancel_estado", int'(db_estado), 0);
        run(3);

        // Randomized commands
        repeat (20000) begin
            iniciar   = ($urandom_range(0, 299) == 0);
            cancelar  = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) pausar = ~pausar;
            limite_ms = W_MS'($urandom_range(0, 5));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
